// File: rtl/io_pkg.sv
// Shared types and constants for the io_mem controller slice:
// FSM state encoding, default bus widths and a one-hot helper.
package io_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        ACK   = 2'd3
    } state_t;

    // One-hot vector for a 1-bit requester index.
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, with the
// last-served pointer advanced only when the caller commits a grant.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic last;

    always_comb begin
        // NOTE: assign a default first so no path leaves grant unassigned (no latch).
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Pointer starts at requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (update && (|grant)) begin
            // NOTE: non-blocking for all clocked state so every reader sees the pre-edge value.
            last <= grant[1];
        end
    end

endmodule

// File: rtl/io_mem_ctrl.sv
// Two-requester controller for io_mem over a shared tri-state data bus.
// Registered FSM: IDLE -> WRITE | READ(xREAD_LAT) -> ACK -> IDLE.
module io_mem_ctrl
    import io_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int READ_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req,
    input  logic [1:0]          we,
    input  logic [2*ADDR_W-1:0] addr,
    input  logic [2*DATA_W-1:0] wdata,
    output logic [1:0]          ack,
    output logic [DATA_W-1:0]   rdata,
    output logic [ADDR_W-1:0]   r_addr,
    output logic [ADDR_W-1:0]   w_addr,
    output logic                mem_wr,
    output logic                mem_rd,
    inout  wire  [DATA_W-1:0]   bus
);

    localparam logic [1:0] LAST_RD = 2'(READ_LAT - 1);

    state_t              state;
    logic                sel;
    logic [DATA_W-1:0]   wdata_q;
    logic [1:0]          lat_cnt;
    logic [1:0]          grant;
    logic                start;
    logic                win;
    logic                win_we;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;

    assign start     = (state == IDLE) && (|req);
    assign win       = grant[1];
    assign win_we    = win ? we[1] : we[0];
    assign win_addr  = win ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
    assign win_wdata = win ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .update (start),
        .grant  (grant)
    );

    // mem_wr is high exactly in WRITE, so it doubles as the bus drive enable;
    // mem_rd can never coincide with it, which keeps the bus contention-free.
    assign bus = mem_wr ? wdata_q : {DATA_W{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel     <= 1'b0;
            wdata_q <= '0;
            lat_cnt <= 2'd0;
            ack     <= 2'b00;
            rdata   <= '0;
            r_addr  <= '0;
            w_addr  <= '0;
            mem_wr  <= 1'b0;
            mem_rd  <= 1'b0;
        end else begin
            ack    <= 2'b00;
            mem_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sel <= win;
                        if (win_we) begin
                            state   <= WRITE;
                            w_addr  <= win_addr;
                            wdata_q <= win_wdata;
                            mem_wr  <= 1'b1;
                        end else begin
                            state   <= READ;
                            r_addr  <= win_addr;
                            mem_rd  <= 1'b1;
                            lat_cnt <= 2'd0;
                        end
                    end
                end
                WRITE: begin
                    state <= ACK;
                    ack   <= onehot2(sel);
                end
                READ: begin
                    if (lat_cnt == LAST_RD) begin
                        rdata  <= bus;
                        mem_rd <= 1'b0;
                        state  <= ACK;
                        ack    <= onehot2(sel);
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_mem_ctrl.sv
// Scoreboard bench for io_mem_ctrl: directed transfers push expectations,
// a negedge monitor pops and compares on every ack / memory strobe.
module tb_io_mem_ctrl;

    localparam int RL = 2;

    typedef struct {
        logic [1:0] ack;
        logic       is_rd;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         issue;
        int         lat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  ack;
    logic [7:0]  rdata;
    logic [7:0]  r_addr;
    logic [7:0]  w_addr;
    logic        mem_wr;
    logic        mem_rd;
    tri1  [7:0]  bus;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          wr_cnt   = 0;
    int          rd_cnt   = 0;
    int          since_wr = 100;
    logic        prev_rd  = 1'b0;
    logic [7:0]  mem [256];

    io_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .READ_LAT(RL)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .ack    (ack),
        .rdata  (rdata),
        .r_addr (r_addr),
        .w_addr (w_addr),
        .mem_wr (mem_wr),
        .mem_rd (mem_rd),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // io_mem model: combinational read while mem_rd, write on the mem_wr edge.
    assign bus = mem_rd ? mem[r_addr] : 8'bz;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (mem_wr) begin
            mem[w_addr] <= bus;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [1:0] a, input logic rd, input logic [7:0] ad,
                        input logic [7:0] wd, input logic [7:0] rdv, input int lat);
        exp_t e;
        e.ack = a; e.is_rd = rd; e.addr = ad; e.wdata = wd;
        e.rdata = rdv; e.issue = cyc; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic set_req(input int r, input logic w, input logic [7:0] a, input logic [7:0] d);
        we[r]          = w;
        addr[r*8 +: 8]  = a;
        wdata[r*8 +: 8] = d;
        req[r]         = 1'b1;
    endtask

    task automatic wait_acks(input logic [1:0] mask, input int n);
        int got = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if ((ack & mask) != 2'b00) got++;
            if (got == n) break;
        end
        check("ack_timeout", 32'(got), 32'(n));
    endtask

    // Single transfer: request, wait for its ack, drop req in the ACK cycle.
    task automatic xfer(input int r, input logic w, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] exp_rd);
        logic [1:0] oh;
        oh = (r == 1) ? 2'b10 : 2'b01;
        push(oh, !w, a, d, exp_rd, w ? 3 : 2 + RL);
        set_req(r, w, a, d);
        wait_acks(oh, 1);
        req[r] = 1'b0;
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            wr_cnt = 0; rd_cnt = 0; since_wr = 100; prev_rd = 1'b0;
        end else begin
            if (mem_wr) begin
                wr_cnt++;
                if (sb.size() == 0) check("unexpected_wr", 32'(mem_wr), 32'h0);
                else begin
                    check("w_addr", 32'(w_addr), 32'(sb[0].addr));
                    check("wr_bus", 32'(bus), 32'(sb[0].wdata));
                    check("wr_dir", 32'(sb[0].is_rd), 32'h0);
                end
            end
            if (mem_rd) begin
                rd_cnt++;
                check("rd_during_wr", 32'(mem_wr), 32'h0);
                if (sb.size() == 0) check("unexpected_rd", 32'(mem_rd), 32'h0);
                else check("r_addr", 32'(r_addr), 32'(sb[0].addr));
                if (!prev_rd) check("turnaround", 32'(since_wr >= 2), 32'h1);
            end
            if (ack != 2'b00) begin
                if (sb.size() == 0) check("unexpected_ack", 32'(ack), 32'h0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ack_vec", 32'(ack), 32'(e.ack));
                    check("rdata", 32'(rdata), 32'(e.rdata));
                    check("ack_bus_hiz", 32'(bus), 32'hFF);
                    check("ack_strobes", 32'({mem_rd, mem_wr}), 32'h0);
                    check("wr_pulses", 32'(wr_cnt), e.is_rd ? 32'h0 : 32'h1);
                    check("rd_cycles", 32'(rd_cnt), e.is_rd ? 32'(RL) : 32'h0);
                    if (e.lat > 0) check("latency", 32'(cyc - e.issue + 1), 32'(e.lat));
                end
                wr_cnt = 0;
                rd_cnt = 0;
            end
            since_wr = mem_wr ? 0 : since_wr + 1;
            prev_rd  = mem_rd;
        end
    end

    initial begin
        rst_n = 1'b0; req = 2'b00; we = 2'b00; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", 32'({ack, mem_wr, mem_rd, rdata, r_addr, w_addr}), 32'h0);
        check("rst_bus", 32'(bus), 32'hFF);
        rst_n = 1'b1;
        @(posedge clk); #1;

        xfer(0, 1'b1, 8'h12, 8'hA5, 8'h00);
        xfer(1, 1'b0, 8'h12, 8'h00, 8'hA5);
        xfer(1, 1'b1, 8'h13, 8'h3C, 8'hA5);

        // Fields change and req drops one cycle after grant; transfer must keep 0x20/0x77.
        push(2'b01, 1'b0, 8'h20, 8'h77, 8'hA5, 3);
        set_req(0, 1'b1, 8'h20, 8'h77);
        @(posedge clk); #1;
        addr[7:0] = 8'h30; wdata[7:0] = 8'h99; req[0] = 1'b0;
        wait_acks(2'b01, 1);
        @(posedge clk); #1;
        xfer(1, 1'b0, 8'h20, 8'h00, 8'h77);
        xfer(0, 1'b0, 8'h30, 8'h00, 8'h00);

        // Reset in the middle of a WRITE: abandoned, no ack, no memory update.
        push(2'b01, 1'b0, 8'h50, 8'hEE, 8'h00, 3);
        set_req(0, 1'b1, 8'h50, 8'hEE);
        @(posedge clk); #1;
        check("mid_wr_seen", 32'(mem_wr), 32'h1);
        #2;
        rst_n = 1'b0; req = 2'b00; sb.delete();
        #1;
        check("midrst_outs", 32'({ack, mem_wr, mem_rd, rdata, r_addr, w_addr}), 32'h0);
        check("midrst_bus", 32'(bus), 32'hFF);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Both requesters held: grants alternate 0,1,0,1 starting with 0.
        push(2'b01, 1'b0, 8'h40, 8'h11, 8'h00, 0);
        push(2'b10, 1'b1, 8'h40, 8'h00, 8'h11, 0);
        push(2'b01, 1'b0, 8'h40, 8'h11, 8'h11, 0);
        push(2'b10, 1'b1, 8'h40, 8'h00, 8'h11, 0);
        set_req(0, 1'b1, 8'h40, 8'h11);
        set_req(1, 1'b0, 8'h40, 8'h00);
        wait_acks(2'b11, 4);
        req = 2'b00;
        @(posedge clk); #1;

        xfer(1, 1'b0, 8'h50, 8'h00, 8'h00);

        repeat (5) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
